// File: rtl/seq_stage_sequencer.sv
// seq_stage_sequencer: multi-cycle SEQ Y86-64 stage sequencer owning pc, valP, stat and the retired count
module seq_stage_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             instructionValid,
  input  logic             needRegids,
  input  logic             needValC,
  input  logic             imem_ready,
  input  logic             imem_error,
  input  logic             dmem_ready,
  input  logic             dmem_error,
  input  logic [63:0]      newPC,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             writeback_en,
  output logic             pcupd_en,
  output logic [63:0]      pc,
  output logic [63:0]      valP,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
  } state_t;
  localparam logic [2:0] STAT_AOK = 3'd1, STAT_HLT = 3'd2, STAT_ADR = 3'd3, STAT_INS = 3'd4;
  state_t           state_q, state_d;
  logic [63:0]      pc_q, pc_d, valp_q, valp_d;
  logic [2:0]       stat_q, stat_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             mem_op;
  // mrmovq, rmmovq, call, ret, pushq, popq touch data memory
  assign mem_op = icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valp_d    = valp_q;
    stat_d    = stat_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE:      state_d = start ? S_FETCH : S_IDLE;
      S_FETCH: if (imem_ready) begin
        if (imem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else if (!instructionValid) begin
          stat_d  = STAT_INS;
          state_d = S_HALT;
        end else if (icode == 4'h0) begin
          stat_d  = STAT_HLT;
          state_d = S_HALT;
        end else begin
          valp_d  = pc_q + 64'd1 + {63'd0, needRegids} + (needValC ? 64'd8 : 64'd0);
          state_d = S_DECODE;
        end
      end
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = mem_op ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: if (dmem_ready) begin
        stat_d  = dmem_error ? STAT_ADR : stat_q;
        state_d = dmem_error ? S_HALT : S_WRITEBACK;
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        pc_d      = newPC;
        retired_d = retired_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      default:     state_d = S_HALT;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      valp_q    <= '0;
      stat_q    <= STAT_AOK;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valp_q    <= valp_d;
      stat_q    <= stat_d;
      retired_q <= retired_d;
    end
  end
  assign fetch_en     = state_q == S_FETCH;
  assign decode_en    = state_q == S_DECODE;
  assign execute_en   = state_q == S_EXECUTE;
  assign memory_en    = state_q == S_MEMORY;
  assign writeback_en = state_q == S_WRITEBACK;
  assign pcupd_en     = state_q == S_PCUPD;
  assign imem_req     = fetch_en;
  assign dmem_req     = memory_en;
  assign halted       = state_q == S_HALT;
  assign pc           = pc_q;
  assign valP         = valp_q;
  assign stat         = stat_q;
  assign retired      = retired_q;
endmodule

// File: tb/tb_seq_stage_sequencer.sv
// tb_seq_stage_sequencer: randomized instruction stream checked every cycle against a per-instruction stage model
module tb_seq_stage_sequencer;
  localparam int CW = 4;
  logic          clk = 0, rst = 1, start = 0;
  logic [3:0]    icode = 0;
  logic          instructionValid = 0, needRegids = 0, needValC = 0;
  logic          imem_ready = 0, imem_error = 0, dmem_ready = 0, dmem_error = 0;
  logic [63:0]   newPC = 0;
  logic          imem_req, dmem_req, fetch_en, decode_en, execute_en, memory_en, writeback_en, pcupd_en, halted;
  logic [63:0]   pc, valP;
  logic [2:0]    stat;
  logic [CW-1:0] retired;

  seq_stage_sequencer #(.RESET_PC(64'h0), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode), .instructionValid(instructionValid),
    .needRegids(needRegids), .needValC(needValC), .imem_ready(imem_ready), .imem_error(imem_error),
    .dmem_ready(dmem_ready), .dmem_error(dmem_error), .newPC(newPC), .imem_req(imem_req),
    .dmem_req(dmem_req), .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
    .memory_en(memory_en), .writeback_en(writeback_en), .pcupd_en(pcupd_en), .pc(pc), .valP(valP),
    .stat(stat), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  int          compared = 0, mismatched = 0;
  // stage index: 0 idle, 1 F, 2 D, 3 E, 4 M, 5 W, 6 P, 7 halt
  int          exp_stage = 0, exp_stat = 1, exp_ret = 0;
  logic [63:0] exp_pc = 0, exp_valp = 0;
  bit          chk = 0;
  int          cyc = 0, mem_cycles = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) if (chk) begin
    cmp("enables", {fetch_en, decode_en, execute_en, memory_en, writeback_en, pcupd_en},
        (exp_stage >= 1 && exp_stage <= 6) ? 64'(6'b100000 >> (exp_stage - 1)) : 64'd0);
    cmp("imem_req", imem_req, exp_stage == 1);
    cmp("dmem_req", dmem_req, exp_stage == 4);
    cmp("halted", halted, exp_stage == 7);
    cmp("pc", pc, exp_pc);
    cmp("valP", valP, exp_valp);
    cmp("stat", stat, exp_stat);
    cmp("retired", retired, exp_ret);
    if (memory_en) mem_cycles++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    start = 0;
  endtask

  task automatic model_reset();
    exp_stage = 0; exp_pc = 0; exp_valp = 0; exp_stat = 1; exp_ret = 0;
  endtask

  task automatic begin_run();
    rst = 1; start = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    step();
    start = 1;
    step();
    exp_stage = 1;
  endtask

  task automatic do_instr(input logic [3:0] ic, input bit vld, input bit rg, input bit vc, input int iw,
                          input bit ie, input int dw, input bit de, input logic [63:0] npc, input bit abort = 0);
    cyc = 0;
    icode = ic; instructionValid = vld; needRegids = rg; needValC = vc;
    for (int k = 0; k <= iw; k++) begin
      imem_ready = (k == iw);
      imem_error = (k == iw) ? ie : 1'($urandom);
      start = 1'($urandom);
      step();
    end
    imem_ready = 0; imem_error = 0;
    if (ie)       begin exp_stat = 3; exp_stage = 7; return; end
    if (!vld)     begin exp_stat = 4; exp_stage = 7; return; end
    if (ic == 0)  begin exp_stat = 2; exp_stage = 7; return; end
    exp_valp = exp_pc + 64'd1 + 64'(rg) + (vc ? 64'd8 : 64'd0);
    exp_stage = 2;
    start = 1'($urandom); step();
    exp_stage = 3;
    start = 1'($urandom); step();
    if (ic inside {4, 5, 8, 9, 10, 11}) begin
      exp_stage = 4;
      for (int k = 0; k <= dw; k++) begin
        dmem_ready = (k == dw);
        dmem_error = (k == dw) ? de : 1'($urandom);
        start = 1'($urandom);
        if (abort && k == 1) begin
          rst = 1;
          model_reset();
          #1;
          cmp("async_rst_memory_en", memory_en, 0);
          cmp("async_rst_dmem_req", dmem_req, 0);
          cmp("async_rst_pc", pc, 64'h0);
          cmp("async_rst_retired", retired, 0);
          cmp("async_rst_stat", stat, 1);
          @(posedge clk);
          #1;
          rst = 0; start = 0; dmem_ready = 0; dmem_error = 0;
          return;
        end
        step();
      end
      dmem_ready = 0; dmem_error = 0;
      if (de) begin exp_stat = 3; exp_stage = 7; return; end
    end
    exp_stage = 5;
    start = 1'($urandom); step();
    exp_stage = 6;
    newPC = npc;
    start = 1'($urandom); step();
    exp_pc = npc;
    exp_ret = (exp_ret + 1) % (1 << CW);
    exp_stage = 1;
  endtask

  task automatic idle_halt(input int n);
    for (int k = 0; k < n; k++) begin
      start = 1'($urandom);
      step();
    end
  endtask

  initial begin
    #1;
    chk = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    step();
    start = 1;
    step();
    exp_stage = 1;
    do_instr(4'h3, 1, 1, 1, 0, 0, 0, 0, 64'h0A);
    cmp("irmovq_cycles", cyc, 5);
    cmp("irmovq_valP", valP, 64'h0A);
    cmp("irmovq_pc", pc, 64'h0A);
    cmp("irmovq_retired", retired, 1);
    mem_cycles = 0;
    do_instr(4'h5, 1, 1, 1, 0, 0, 3, 0, 64'h14);
    cmp("mrmovq_cycles", cyc, 9);
    cmp("mrmovq_mem_cycles", mem_cycles, 4);
    cmp("mrmovq_valP", valP, 64'h14);
    cmp("mrmovq_retired", retired, 2);
    for (int n = 0; n < 14; n++)
      do_instr(4'(1 + $urandom % 11), 1, 1'($urandom), 1'($urandom), $urandom % 3, 0, $urandom % 3, 0,
               {$urandom, $urandom});
    cmp("wrap_retired0", retired, 0);
    do_instr(4'h6, 1, 1, 0, 1, 0, 0, 0, 64'h20);
    cmp("wrap_retired1", retired, 1);
    do_instr(4'h7, 0, 1, 0, 1, 0, 0, 0, 64'h99);
    idle_halt(4);
    cmp("ins_stat", stat, 4);
    cmp("ins_pc", pc, 64'h20);
    cmp("ins_halted", halted, 1);
    begin_run();
    do_instr(4'h0, 1, 0, 0, 2, 0, 0, 0, 64'h77);
    idle_halt(5);
    cmp("hlt_stat", stat, 2);
    cmp("hlt_pc", pc, 64'h0);
    cmp("hlt_retired", retired, 0);
    begin_run();
    do_instr(4'h3, 0, 1, 1, 1, 1, 0, 0, 64'h77);
    idle_halt(2);
    cmp("adr_priority_stat", stat, 3);
    begin_run();
    do_instr(4'h2, 1, 1, 0, 0, 0, 0, 0, 64'h40);
    do_instr(4'h4, 1, 1, 1, 1, 0, 2, 1, 64'h99);
    idle_halt(2);
    cmp("dmem_err_stat", stat, 3);
    cmp("dmem_err_pc", pc, 64'h40);
    cmp("dmem_err_retired", retired, 1);
    begin_run();
    do_instr(4'h3, 1, 1, 1, 0, 0, 0, 0, 64'h55);
    do_instr(4'h5, 1, 1, 1, 0, 0, 4, 0, 64'h66, 1);
    step();
    begin_run();
    for (int n = 0; n < 40; n++) begin
      if (exp_stage == 7) begin_run();
      do_instr(4'($urandom), ($urandom % 8) != 0, 1'($urandom), 1'($urandom), $urandom % 3,
               ($urandom % 10) == 0, $urandom % 3, ($urandom % 8) == 0, {$urandom, $urandom});
    end
    step();
    chk = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
